// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment display between NUM_REQ value sources,
// with a minimum hold time per owner. Optional alarm preemption of source 0: SEG_ARB_PREEMPT_EN.
module seg_display_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 50_000_000,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        grant_out,
  output logic [DATA_W-1:0]         display_value_out,
  output logic                      display_trigger_out,
  output logic [IDX_W-1:0]          active_src_out,
  output logic                      busy_out
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int POS_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_HOLD
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   winner_reg, winner_next;
  logic [IDX_W-1:0]   owner_reg;
  logic               load_winner;
  logic [CNT_W-1:0]   hold_cnt_reg;
  logic               first_done_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [DATA_W-1:0]  value_reg;
  logic               trigger_reg;
  logic [DATA_W-1:0]  src_data [NUM_REQ];
  logic [IDX_W-1:0]   arb_idx;
  logic [POS_W-1:0]   arb_pos;
  logic               arb_found;
  logic               hold_expired;
  logic               owner_drop;

`ifdef SEG_ARB_PREEMPT_EN
  logic               req0_q_reg;
  logic               preempt_reg, preempt_next;
  logic               req0_rise;

  assign req0_rise = req_in[0] & ~req0_q_reg;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
    assign src_data[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  // First requester at or after rr_ptr, wrapping around the source list.
  always_comb begin
    arb_idx   = '0;
    arb_pos   = '0;
    arb_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_pos = {1'b0, rr_ptr_reg} + POS_W'(k);
      if (arb_pos >= POS_W'(NUM_REQ)) arb_pos = arb_pos - POS_W'(NUM_REQ);
      if (!arb_found && req_in[arb_pos[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_pos[IDX_W-1:0];
      end
    end
  end

  assign owner_drop   = ~req_in[owner_reg];
  assign hold_expired = (hold_cnt_reg == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    load_winner  = 1'b0;
    winner_next  = arb_idx;
`ifdef SEG_ARB_PREEMPT_EN
    preempt_next = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (|req_in) begin
          load_winner = 1'b1;
          state_next  = ST_GRANT;
        end
      end
      ST_GRANT: state_next = ST_HOLD;
      ST_HOLD: begin
`ifdef SEG_ARB_PREEMPT_EN
        if (req0_rise && owner_reg != '0) begin
          winner_next  = '0;
          preempt_next = 1'b1;
          load_winner  = 1'b1;
          state_next   = ST_GRANT;
        end else
`endif
        if (owner_drop) begin
          state_next = ST_IDLE;
        end else if (hold_expired) begin
          // Owner is still requesting here, so arbitration always finds a winner.
          load_winner = 1'b1;
          state_next  = ST_GRANT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr_reg     <= '0;
      winner_reg     <= '0;
      owner_reg      <= '0;
      hold_cnt_reg   <= '0;
      first_done_reg <= 1'b0;
      grant_reg      <= '0;
      value_reg      <= '0;
      trigger_reg    <= 1'b0;
`ifdef SEG_ARB_PREEMPT_EN
      req0_q_reg     <= 1'b0;
      preempt_reg    <= 1'b0;
`endif
    end else begin
      trigger_reg <= 1'b0;
`ifdef SEG_ARB_PREEMPT_EN
      req0_q_reg  <= req_in[0];
`endif
      if (load_winner) begin
        winner_reg  <= winner_next;
`ifdef SEG_ARB_PREEMPT_EN
        preempt_reg <= preempt_next;
`endif
      end
      case (state_reg)
        ST_GRANT: begin
          grant_reg    <= NUM_REQ'(1) << winner_reg;
          owner_reg    <= winner_reg;
          value_reg    <= src_data[winner_reg];
          hold_cnt_reg <= '0;
          if (!first_done_reg) begin
            trigger_reg    <= 1'b1;
            first_done_reg <= 1'b1;
          end
`ifdef SEG_ARB_PREEMPT_EN
          if (!preempt_reg)
`endif
          rr_ptr_reg <= (winner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : winner_reg + 1'b1;
        end
        ST_HOLD: begin
          value_reg <= src_data[owner_reg];
          if (!hold_expired) hold_cnt_reg <= hold_cnt_reg + 1'b1;
          if (owner_drop) grant_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign grant_out           = grant_reg;
  assign display_value_out   = value_reg;
  assign display_trigger_out = trigger_reg;
  assign active_src_out      = owner_reg;
  assign busy_out            = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a short hold time (HOLD_CYCLES=4).
module tb_seg_display_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 16;

  logic                      clk_in;
  logic                      rst_n_in;
  logic [NUM_REQ-1:0]        req_in;
  logic [DATA_W-1:0]         d0, d1, d2;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        grant_out;
  logic [DATA_W-1:0]         display_value_out;
  logic                      display_trigger_out;
  logic [1:0]                active_src_out;
  logic                      busy_out;

  int checks_cnt;
  int fail_cnt;

  assign data_in = {d2, d1, d0};

  seg_display_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .HOLD_CYCLES(4)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .req_in(req_in),
    .data_in(data_in),
    .grant_out(grant_out),
    .display_value_out(display_value_out),
    .display_trigger_out(display_trigger_out),
    .active_src_out(active_src_out),
    .busy_out(busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [NUM_REQ-1:0] exp_grant [4];
    logic [DATA_W-1:0]  exp_val [4];
    logic [1:0]         exp_src [4];
    checks_cnt = 0;
    fail_cnt   = 0;
    rst_n_in   = 1'b0;
    req_in     = '0;
    d0 = 16'h1111;
    d1 = 16'h1234;
    d2 = 16'h2222;

    // Reset state
    tick();
    tick();
    check("rst_grant", 32'(grant_out), 32'h0);
    check("rst_value", 32'(display_value_out), 32'h0);
    check("rst_trig", 32'(display_trigger_out), 32'h0);
    check("rst_src", 32'(active_src_out), 32'h0);
    check("rst_busy", 32'(busy_out), 32'h0);

    // Round robin with all three requesting: 0,1,2,0, 5 cycles per owner
    rst_n_in = 1'b1;
    req_in   = 3'b111;
    tick();
    check("rr_grant_lat1", 32'(grant_out), 32'h0);
    check("rr_busy_grant", 32'(busy_out), 32'h1);
    tick();
    check("rr_grant0", 32'(grant_out), 32'b001);
    check("rr_trig0", 32'(display_trigger_out), 32'h1);
    check("rr_val0", 32'(display_value_out), 32'h1111);
    exp_grant[0] = 3'b001; exp_val[0] = 16'h1111; exp_src[0] = 2'd0;
    exp_grant[1] = 3'b010; exp_val[1] = 16'h1234; exp_src[1] = 2'd1;
    exp_grant[2] = 3'b100; exp_val[2] = 16'h2222; exp_src[2] = 2'd2;
    exp_grant[3] = 3'b001; exp_val[3] = 16'h1111; exp_src[3] = 2'd0;
    for (int g = 1; g < 4; g++) begin
      repeat (4) tick();
      check("rr_hold_prev", 32'(grant_out), 32'(exp_grant[g-1]));
      tick();
      check("rr_grant", 32'(grant_out), 32'(exp_grant[g]));
      check("rr_val", 32'(display_value_out), 32'(exp_val[g]));
      check("rr_src", 32'(active_src_out), 32'(exp_src[g]));
      check("rr_trig", 32'(display_trigger_out), 32'h0);
    end

    // Asynchronous reset in the middle of HOLD
    #2;
    rst_n_in = 1'b0;
    #1;
    check("arst_grant", 32'(grant_out), 32'h0);
    check("arst_value", 32'(display_value_out), 32'h0);
    check("arst_busy", 32'(busy_out), 32'h0);
    req_in = '0;
    tick();
    rst_n_in = 1'b1;

    // Single requester 1 after reset: grant two edges later, trigger re-pulses
    req_in = 3'b010;
    tick();
    check("s1_grant_lat1", 32'(grant_out), 32'h0);
    tick();
    check("s1_grant", 32'(grant_out), 32'b010);
    check("s1_value", 32'(display_value_out), 32'h1234);
    check("s1_trig", 32'(display_trigger_out), 32'h1);
    check("s1_src", 32'(active_src_out), 32'h1);
    tick();
    check("s1_trig_once", 32'(display_trigger_out), 32'h0);

    // Live update of owner's value during HOLD
    d1 = 16'hABCD;
    tick();
    check("live_value", 32'(display_value_out), 32'hABCD);

    // Sole requester re-granted at expiry, no second trigger
    repeat (2) tick();
    check("regrant1_hold", 32'(grant_out), 32'b010);
    tick();
    check("regrant1_grant", 32'(grant_out), 32'b010);
    check("regrant1_trig", 32'(display_trigger_out), 32'h0);

    // Owner drops request: grant falls next edge, value retained
    req_in = 3'b000;
    tick();
    check("drop1_grant", 32'(grant_out), 32'h0);
    check("drop1_busy", 32'(busy_out), 32'h0);
    check("drop1_value", 32'(display_value_out), 32'hABCD);

    // Source 2 drops at hold_cnt=1
    req_in = 3'b100;
    tick();
    tick();
    check("s2_grant", 32'(grant_out), 32'b100);
    check("s2_value", 32'(display_value_out), 32'h2222);
    tick();
    req_in = 3'b000;
    tick();
    check("drop2_grant", 32'(grant_out), 32'h0);
    check("drop2_busy", 32'(busy_out), 32'h0);
    check("drop2_value", 32'(display_value_out), 32'h2222);
    check("drop2_src", 32'(active_src_out), 32'h2);

    // Only source 0 requesting past expiry
    req_in = 3'b001;
    repeat (2) tick();
    check("s0_grant", 32'(grant_out), 32'b001);
    check("s0_value", 32'(display_value_out), 32'h1111);
    repeat (4) tick();
    check("s0_regrant_hold", 32'(grant_out), 32'b001);
    check("s0_regrant_busy", 32'(busy_out), 32'h1);
    tick();
    check("s0_regrant", 32'(grant_out), 32'b001);
    check("s0_regrant_trig", 32'(display_trigger_out), 32'h0);

`ifdef SEG_ARB_PREEMPT_EN
    // Alarm source 0 preempts source 2 in HOLD
    req_in = 3'b000;
    tick();
    req_in = 3'b100;
    repeat (2) tick();
    check("pre_s2_grant", 32'(grant_out), 32'b100);
    tick();
    req_in = 3'b101;
    tick();
    check("pre_grant_cycle", 32'(grant_out), 32'b100);
    tick();
    check("pre_grant0", 32'(grant_out), 32'b001);
    check("pre_src0", 32'(active_src_out), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
